// File: rtl/loop_player.sv
// Single-channel audio looper: records dry samples into a circular RAM and
// plays them back mixed with the live input, with optional overdub.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   sample_valid_in one-cycle strobe per audio sample
//   data_dry        signed live sample, valid with sample_valid_in
//   rec_pulse       record / overdub command pulse
//   play_pulse      play / stop command pulse
//   clear_pulse     discard loop command pulse
//   data_wet        signed output sample
//   data_valid_out  one-cycle strobe marking data_wet, 2 cycles after input
//   loop_len        recorded loop length in samples, 0 when empty
//   state_out       EMPTY=0 RECORD=1 PLAY=2 OVERDUB=3 STOPPED=4
module loop_player #(
    parameter int WIDTH       = 16,
    parameter int MAX_SAMPLES = 30000
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_valid_in,
    input  logic [WIDTH-1:0]               data_dry,
    input  logic                           rec_pulse,
    input  logic                           play_pulse,
    input  logic                           clear_pulse,
    output logic [WIDTH-1:0]               data_wet,
    output logic                           data_valid_out,
    output logic [$clog2(MAX_SAMPLES):0]   loop_len,
    output logic [2:0]                     state_out
);

    localparam int AW = $clog2(MAX_SAMPLES);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_SAMPLES);

    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] RECORD  = 3'd1;
    localparam logic [2:0] PLAY    = 3'd2;
    localparam logic [2:0] OVERDUB = 3'd3;
    localparam logic [2:0] STOPPED = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Commands resolved by priority: clear > rec > play.
    logic cmd_clr;
    logic cmd_rec;
    logic cmd_play;

    assign cmd_clr  = clear_pulse;
    assign cmd_rec  = rec_pulse & ~clear_pulse;
    assign cmd_play = play_pulse & ~clear_pulse & ~rec_pulse;

    logic          rec_wr;
    logic          rd_adv;
    logic          rptr_wrap;
    logic [AW-1:0] rptr_inc;
    logic [LW-1:0] len_inc;

    assign rec_wr    = (state == RECORD) && sample_valid_in
                       && (loop_len < MAX_LEN);
    assign rd_adv    = ((state == PLAY) || (state == OVERDUB))
                       && sample_valid_in;
    assign rptr_wrap = (LW'(rptr) + LW'(1)) == loop_len;
    assign rptr_inc  = rptr_wrap ? '0 : rptr + 1'b1;
    // Length including a sample arriving in this same cycle.
    assign len_inc   = loop_len + LW'(rec_wr);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= EMPTY;
            wptr     <= '0;
            rptr     <= '0;
            loop_len <= '0;
        end else begin
            if (rec_wr) begin
                wptr     <= wptr + 1'b1;
                loop_len <= len_inc;
            end
            if (rd_adv) begin
                rptr <= rptr_inc;
            end
            if (cmd_clr) begin
                state    <= EMPTY;
                loop_len <= '0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (cmd_rec) begin
                            state    <= RECORD;
                            wptr     <= '0;
                            loop_len <= '0;
                        end
                    end
                    RECORD: begin
                        if (cmd_rec) begin
                            if (len_inc != '0) begin
                                state <= PLAY;
                                rptr  <= '0;
                            end else begin
                                state <= EMPTY;
                            end
                        end else if (loop_len == MAX_LEN) begin
                            // RAM full: fall straight into playback.
                            state <= PLAY;
                            rptr  <= '0;
                        end
                    end
                    PLAY: begin
                        if (cmd_rec) begin
                            state <= OVERDUB;
                        end else if (cmd_play) begin
                            state <= STOPPED;
                        end
                    end
                    OVERDUB: begin
                        if (cmd_rec || cmd_play) begin
                            state <= PLAY;
                        end
                    end
                    STOPPED: begin
                        if (cmd_play) begin
                            state <= PLAY;
                            rptr  <= '0;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign state_out = state;

    // Stage 1: RAM read in flight alongside the dry sample.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_dry;
    logic             s1_mix;
    logic             s1_wb;
    logic [AW-1:0]    s1_addr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_dry   <= '0;
            s1_mix   <= 1'b0;
            s1_wb    <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= sample_valid_in;
            s1_dry   <= data_dry;
            s1_mix   <= rd_adv;
            s1_wb    <= (state == OVERDUB) && sample_valid_in;
            s1_addr  <= rptr;
        end
    end

    logic [WIDTH-1:0] ram_q;
    logic signed [WIDTH:0] sum;
    logic [WIDTH-1:0] mix_val;
    logic             use_mix;
    logic             ob_wr;

    // One extra bit of headroom, then halve: can never overflow.
    assign sum     = $signed({s1_dry[WIDTH-1], s1_dry})
                   + $signed({ram_q[WIDTH-1], ram_q});
    assign mix_val = WIDTH'(sum >>> 1);
    // A clear landing on an in-flight sample drops the loop contribution.
    assign use_mix = s1_mix & ~clear_pulse;
    assign ob_wr   = s1_valid & s1_wb & ~clear_pulse;

    // Stage 2: output register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_wet       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= s1_valid;
            if (s1_valid) begin
                data_wet <= use_mix ? mix_val : s1_dry;
            end
        end
    end

    // Record and overdub writes can never coincide: overdub write-back
    // needs a loop, recording only happens after a clear.
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;

    assign ram_we    = rec_wr | ob_wr;
    assign ram_waddr = ob_wr ? s1_addr : wptr;
    assign ram_wdata = ob_wr ? mix_val : data_dry;

    logic [WIDTH-1:0] mem [0:MAX_SAMPLES-1];

    // Read-first dual-port RAM, contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (sample_valid_in) begin
            ram_q <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_loop_player.sv
// Directed self-checking bench for loop_player (MAX_SAMPLES=8).
// Ports: none; drives the DUT and prints a CHECKS/ERRORS summary.
module tb_loop_player;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sample_valid_in = 1'b0;
    logic [15:0] data_dry = '0;
    logic        rec_pulse = 1'b0;
    logic        play_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic [15:0] data_wet;
    logic        data_valid_out;
    logic [3:0]  loop_len;
    logic [2:0]  state_out;

    int checks = 0;
    int errors = 0;

    loop_player #(.WIDTH(16), .MAX_SAMPLES(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .data_dry        (data_dry),
        .rec_pulse       (rec_pulse),
        .play_pulse      (play_pulse),
        .clear_pulse     (clear_pulse),
        .data_wet        (data_wet),
        .data_valid_out  (data_valid_out),
        .loop_len        (loop_len),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    // One 3-cycle slot: drive in cycle c, observe valid at c+1 and c+2.
    task automatic step(input logic [15:0] d, input logic v,
                        input logic r, input logic p, input logic c,
                        output logic [15:0] w, output logic early,
                        output logic on);
        @(posedge clk_in); #1;
        sample_valid_in = v; data_dry = d;
        rec_pulse = r; play_pulse = p; clear_pulse = c;
        @(posedge clk_in); #1;
        sample_valid_in = 0; rec_pulse = 0;
        play_pulse = 0; clear_pulse = 0;
        early = data_valid_out;
        @(posedge clk_in); #1;
        on = data_valid_out;
        w = data_wet;
    endtask

    task automatic cmd(input logic r, input logic p, input logic c);
        logic [15:0] w;
        logic e, o;
        step(16'd0, 1'b0, r, p, c, w, e, o);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (state_out !== 3'd0 || loop_len !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d len=%0d want 0 0",
                     state_out, loop_len);
        end
        checks++;
        if (data_wet !== 16'd0 || data_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got wet=%0d v=%0d want 0 0",
                     data_wet, data_valid_out);
        end
        rst_in = 0;
    endtask

    task automatic test_record_play;
        logic [15:0] w, rec_d [3], exp_p [4];
        logic e, o;
        rec_d = '{16'd100, 16'd200, 16'd300};
        exp_p = '{16'd50, 16'd100, 16'd150, 16'd50};
        step(16'd123, 1'b1, 1'b0, 1'b1, 1'b0, w, e, o);
        checks++;
        if (w !== 16'd123 || state_out !== 3'd0) begin
            errors++;
            $display("FAIL empty_pass got wet=%0d st=%0d want 123 0",
                     w, state_out);
        end
        cmd(1, 0, 0);
        checks++;
        if (state_out !== 3'd1) begin
            errors++;
            $display("FAIL rec_state got %0d want 1", state_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(rec_d[i], 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== rec_d[i] || {e, o} !== 2'b01) begin
                errors++;
                $display("FAIL rec_wet[%0d] got %0d v=%b%b want %0d v=01",
                         i, w, e, o, rec_d[i]);
            end
        end
        cmd(1, 0, 0);
        checks++;
        if (state_out !== 3'd2 || loop_len !== 4'd3) begin
            errors++;
            $display("FAIL play_entry got st=%0d len=%0d want 2 3",
                     state_out, loop_len);
        end
        for (int i = 0; i < 4; i++) begin
            step(16'd0, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== exp_p[i] || {e, o} !== 2'b01) begin
                errors++;
                $display("FAIL play_wet[%0d] got %0d v=%b%b want %0d v=01",
                         i, w, e, o, exp_p[i]);
            end
        end
    endtask

    task automatic test_overdub;
        logic [15:0] w, exp_o [3], exp_p [3];
        logic e, o;
        exp_o = '{16'd100, 16'd150, 16'd200};
        exp_p = '{16'd50, 16'd75, 16'd100};
        cmd(0, 1, 0);
        checks++;
        if (state_out !== 3'd4) begin
            errors++;
            $display("FAIL stop_state got %0d want 4", state_out);
        end
        step(16'd77, 1'b1, 1'b1, 1'b0, 1'b0, w, e, o);
        checks++;
        if (w !== 16'd77 || state_out !== 3'd4) begin
            errors++;
            $display("FAIL stop_pass got wet=%0d st=%0d want 77 4",
                     w, state_out);
        end
        cmd(0, 1, 0);
        cmd(1, 0, 0);
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL odub_state got %0d want 3", state_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(16'd100, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== exp_o[i]) begin
                errors++;
                $display("FAIL odub_wet[%0d] got %0d want %0d",
                         i, w, exp_o[i]);
            end
        end
        cmd(0, 1, 0);
        checks++;
        if (state_out !== 3'd2 || loop_len !== 4'd3) begin
            errors++;
            $display("FAIL odub_exit got st=%0d len=%0d want 2 3",
                     state_out, loop_len);
        end
        for (int i = 0; i < 3; i++) begin
            step(16'd0, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== exp_p[i]) begin
                errors++;
                $display("FAIL odub_play[%0d] got %0d want %0d",
                         i, w, exp_p[i]);
            end
        end
    endtask

    task automatic test_mix_limits;
        logic [15:0] w, dry [3], exp_m [3];
        logic e, o;
        dry   = '{16'h7FFF, 16'h8000, 16'h8000};
        exp_m = '{16'h7FFF, 16'h8000, 16'hFFFF};
        cmd(0, 0, 1);
        checks++;
        if (state_out !== 3'd0 || loop_len !== 4'd0) begin
            errors++;
            $display("FAIL clear got st=%0d len=%0d want 0 0",
                     state_out, loop_len);
        end
        cmd(1, 0, 0);
        step(16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
        step(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
        cmd(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(dry[i], 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== exp_m[i]) begin
                errors++;
                $display("FAIL mix_lim[%0d] got %0d want %0d",
                         i, $signed(w), $signed(exp_m[i]));
            end
        end
    endtask

    task automatic test_auto_stop;
        logic [15:0] w, d;
        logic e, o;
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            d = 16'(10 * (i + 1));
            step(d, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            if (i < 8) begin
                checks++;
                if (w !== d) begin
                    errors++;
                    $display("FAIL auto_rec[%0d] got %0d want %0d", i, w, d);
                end
            end
            if (i == 7) begin
                checks++;
                if (state_out !== 3'd2 || loop_len !== 4'd8) begin
                    errors++;
                    $display("FAIL auto_stop got st=%0d len=%0d want 2 8",
                             state_out, loop_len);
                end
            end
            if (i == 8) begin
                checks++;
                if (w !== 16'd50) begin
                    errors++;
                    $display("FAIL auto_s9 got %0d want 50", w);
                end
            end
            if (i == 9) begin
                checks++;
                if (w !== 16'd60) begin
                    errors++;
                    $display("FAIL auto_s10 got %0d want 60", w);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(16'd0, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
            checks++;
            if (w !== 16'(5 * (i + 3))) begin
                errors++;
                $display("FAIL auto_ram[%0d] got %0d want %0d",
                         i, w, 5 * (i + 3));
            end
        end
        checks++;
        if (loop_len !== 4'd8) begin
            errors++;
            $display("FAIL auto_len got %0d want 8", loop_len);
        end
    endtask

    task automatic test_priority;
        logic [15:0] w;
        logic e, o;
        step(16'd20, 1'b1, 1'b1, 1'b1, 1'b1, w, e, o);
        checks++;
        if (w !== 16'd15 || {e, o} !== 2'b01) begin
            errors++;
            $display("FAIL prio_wet got %0d v=%b%b want 15 v=01", w, e, o);
        end
        checks++;
        if (state_out !== 3'd0 || loop_len !== 4'd0) begin
            errors++;
            $display("FAIL prio_state got st=%0d len=%0d want 0 0",
                     state_out, loop_len);
        end
        step(16'hFFF9, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
        checks++;
        if (w !== 16'hFFF9) begin
            errors++;
            $display("FAIL prio_dry got %0d want -7", $signed(w));
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] w;
        logic e, o;
        cmd(1, 0, 0);
        step(16'd1000, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
        step(16'd2000, 1'b1, 1'b0, 1'b0, 1'b0, w, e, o);
        cmd(1, 0, 0);
        cmd(1, 0, 0);
        checks++;
        if (state_out !== 3'd3 || data_wet !== 16'd2000) begin
            errors++;
            $display("FAIL ar_setup got st=%0d wet=%0d want 3 2000",
                     state_out, data_wet);
        end
        @(posedge clk_in); #1;
        sample_valid_in = 1; data_dry = 16'd0;
        @(posedge clk_in); #1;
        sample_valid_in = 0;
        #2 rst_in = 1;
        #1;
        checks++;
        if (data_wet !== 16'd0 || data_valid_out !== 1'b0 ||
            state_out !== 3'd0 || loop_len !== 4'd0) begin
            errors++;
            $display("FAIL ar_now got wet=%0d v=%0d st=%0d len=%0d want 0",
                     data_wet, data_valid_out, state_out, loop_len);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_in); #1;
            checks++;
            if (data_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL ar_valid[%0d] got 1 want 0", i);
            end
        end
        rst_in = 0;
        @(posedge clk_in); #1;
        checks++;
        if (state_out !== 3'd0 || data_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ar_after got st=%0d v=%0d want 0 0",
                     state_out, data_valid_out);
        end
    endtask

    initial begin
        test_reset;
        test_record_play;
        test_overdub;
        test_mix_limits;
        test_auto_stop;
        test_priority;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
